seg_frame_arbiter: RTL and testbench



---
 rtl/seg_frame_arbiter.sv | 140 ++++++++++++++
 tb/tb_seg_frame_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_arbiter.sv
// rtl/seg_frame_arbiter.sv - round-robin arbiter sharing the seven-segment frame between producers
module seg_frame_arbiter #(
    parameter int NUMCELLS   = 4,
    parameter int NUMREQ     = 3,
    parameter int HOLD_TICKS = 50000000,
    parameter int HOLD_W     = 26
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUMREQ-1:0]            req,
    input  logic [8*NUMCELLS*NUMREQ-1:0] frame_in,
    output logic [NUMREQ-1:0]            ack,
    output logic [8*NUMCELLS-1:0]        cellval_out,
    output logic [2:0]                   owner,
    output logic                         busy
);

    localparam int FW  = 8 * NUMCELLS;
    localparam int RRW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] dwell_q, dwell_d;
    logic [FW-1:0]     cellval_q, cellval_d;
    logic [2:0]        owner_q, owner_d;
    logic [RRW-1:0]    rr_q, rr_d;
    logic [NUMREQ-1:0] ack_q, ack_d;
    logic              busy_q, busy_d;

    logic [RRW-1:0]    winner;
    logic [FW-1:0]     sel_frame;
    logic              grant;

    // Pick the requester closest after the pointer; the pointer itself ranks last so a
    // continuously requesting owner yields to every other active requester first.
    function automatic logic [RRW-1:0] rr_pick(input logic [NUMREQ-1:0] r,
                                               input logic [RRW-1:0]    ptr);
        logic [RRW-1:0] w;
        int             best;
        int             d;
        w    = '0;
        best = NUMREQ + 1;
        for (int i = 0; i < NUMREQ; i++) begin
            d = (i > int'(ptr)) ? (i - int'(ptr)) : (i + NUMREQ - int'(ptr));
            if (r[i] && (d < best)) begin
                best = d;
                w    = RRW'(i);
            end
        end
        return w;
    endfunction

    // Winner selection and the frame it would bring onto the display.
    always_comb begin
        winner    = rr_pick(req, rr_q);
        sel_frame = '0;
        for (int i = 0; i < NUMREQ; i++) begin
            if (winner == RRW'(i)) begin
                sel_frame = frame_in[FW*i +: FW];
            end
        end
    end

    // Next-state logic: grant from IDLE or on dwell expiry, otherwise count the dwell down.
    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        cellval_d = cellval_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        ack_d     = '0;
        busy_d    = busy_q;
        grant     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant = 1'b1;
                end
            end
            ST_SHOW: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - HOLD_W'(1);
                end else if (|req) begin
                    grant = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (grant) begin
            state_d   = ST_SHOW;
            busy_d    = 1'b1;
            dwell_d   = HOLD_W'(HOLD_TICKS - 1);
            cellval_d = sel_frame;
            owner_d   = 3'(winner);
            rr_d      = winner;
            for (int i = 0; i < NUMREQ; i++) begin
                ack_d[i] = (winner == RRW'(i));
            end
        end
    end

    // State register with synchronous active-low reset; pointer resets so requester 0 wins first.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            dwell_q   <= '0;
            cellval_q <= '0;
            owner_q   <= '0;
            rr_q      <= RRW'(NUMREQ - 1);
            ack_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            cellval_q <= cellval_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign ack         = ack_q;
    assign cellval_out = cellval_q;
    assign owner       = owner_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_seg_frame_arbiter.sv
// tb/tb_seg_frame_arbiter.sv - scoreboard bench for seg_frame_arbiter
module tb_seg_frame_arbiter;

    logic        clock;
    logic        resetn;
    logic [2:0]  req;
    logic [31:0] fr0, fr1, fr2;
    logic [95:0] frame_in;
    logic [2:0]  ack;
    logic [31:0] cellval_out;
    logic [2:0]  owner;
    logic        busy;

    typedef struct {
        int          own;
        logic [31:0] frame;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    assign frame_in = {fr2, fr1, fr0};

    seg_frame_arbiter #(
        .NUMCELLS  (4),
        .NUMREQ    (3),
        .HOLD_TICKS(4),
        .HOLD_W    (3)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .frame_in   (frame_in),
        .ack        (ack),
        .cellval_out(cellval_out),
        .owner      (owner),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = 3'b000;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (|ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit got;
        resetn = 1'b0;
        req    = 3'b111;
        fr0 = 32'hA0A0A0A0; fr1 = 32'hB1B1B1B1; fr2 = 32'hC2C2C2C2;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({cellval_out, owner, ack, busy} !== 39'd0) begin
                miscompares++;
                $display("FAIL reset_values cyc %0d: got %h expected 0", i, {cellval_out, owner, ack, busy});
            end
        end
        resetn = 1'b1;
        sb.push_back('{0, fr0, cyc + 1});
        wait_ack(10, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL reset_first_grant: no ack seen, expected ack=001");
        end else begin
            e = sb.pop_front();
            vectors++;
            if ({ack, owner, cellval_out, busy} !== {3'(1 << e.own), 3'(e.own), e.frame, 1'b1}) begin
                miscompares++;
                $display("FAIL reset_first_grant: got ack=%b owner=%0d frame=%h busy=%b expected ack=%b owner=%0d frame=%h busy=1",
                         ack, owner, cellval_out, busy, 3'(1 << e.own), e.own, e.frame);
            end
            if (cyc !== e.cyc) begin
                miscompares++;
                $display("FAIL reset_first_grant_time: got cycle %0d expected %0d", cyc, e.cyc);
            end
        end
        req = 3'b000;
    endtask

    task automatic test_single();
        bit got;
        int busy_cycles;
        do_reset();
        fr1 = 32'h3F065B4F;
        req = 3'b010;
        sb.push_back('{1, 32'h3F065B4F, cyc + 1});
        wait_ack(10, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL single_grant: no ack seen, expected ack=010");
        end else begin
            e = sb.pop_front();
            vectors++;
            if ({ack, owner, cellval_out, busy} !== {3'(1 << e.own), 3'(e.own), e.frame, 1'b1}) begin
                miscompares++;
                $display("FAIL single_grant: got ack=%b owner=%0d frame=%h busy=%b expected ack=%b owner=%0d frame=%h busy=1",
                         ack, owner, cellval_out, busy, 3'(1 << e.own), e.own, e.frame);
            end
            if (cyc !== e.cyc) begin
                miscompares++;
                $display("FAIL single_grant_time: got cycle %0d expected %0d", cyc, e.cyc);
            end
        end
        req = 3'b000;
        busy_cycles = 1;
        tick();
        vectors++;
        if (ack !== 3'b000) begin
            miscompares++;
            $display("FAIL single_ack_pulse: got ack=%b one cycle after grant expected 000", ack);
        end
        for (int i = 0; i < 10 && busy === 1'b1; i++) begin
            busy_cycles++;
            tick();
        end
        vectors++;
        if (busy_cycles !== 4) begin
            miscompares++;
            $display("FAIL single_dwell: got busy for %0d cycles expected 4", busy_cycles);
        end
        tick();
        vectors++;
        if ({busy, owner, cellval_out} !== {1'b0, 3'd1, 32'h3F065B4F}) begin
            miscompares++;
            $display("FAIL single_idle_retain: got busy=%b owner=%0d frame=%h expected busy=0 owner=1 frame=3f065b4f",
                     busy, owner, cellval_out);
        end
    endtask

    task automatic test_round_robin();
        int grants;
        int drops;
        int base;
        do_reset();
        fr0 = 32'h00000011; fr1 = 32'h00002200; fr2 = 32'h00330000;
        req  = 3'b111;
        base = cyc;
        sb.push_back('{0, fr0, base + 1});
        sb.push_back('{1, fr1, base + 5});
        sb.push_back('{2, fr2, base + 9});
        sb.push_back('{0, fr0, base + 13});
        grants = 0;
        drops  = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (|ack) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rr_unexpected_ack: got ack=%b expected none", ack);
                end else begin
                    e = sb.pop_front();
                    if ({ack, owner, cellval_out, busy} !== {3'(1 << e.own), 3'(e.own), e.frame, 1'b1}) begin
                        miscompares++;
                        $display("FAIL rr_grant: got ack=%b owner=%0d frame=%h expected ack=%b owner=%0d frame=%h",
                                 ack, owner, cellval_out, 3'(1 << e.own), e.own, e.frame);
                    end
                    vectors++;
                    if (cyc !== e.cyc) begin
                        miscompares++;
                        $display("FAIL rr_grant_time: got cycle %0d expected %0d", cyc, e.cyc);
                    end
                end
                grants++;
            end
            if (grants > 0 && busy !== 1'b1) drops++;
        end
        vectors++;
        if (grants !== 4 || drops !== 0) begin
            miscompares++;
            $display("FAIL rr_summary: got %0d grants %0d busy drops expected 4 grants 0 drops", grants, drops);
        end
        req = 3'b000;
    endtask

    task automatic test_late_arrival();
        bit got;
        int g0;
        do_reset();
        fr0 = 32'h0000AAAA; fr2 = 32'hCCCC0000;
        req = 3'b001;
        sb.push_back('{0, fr0, cyc + 1});
        wait_ack(10, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL late_first_grant: no ack seen expected ack=001");
        end else begin
            e = sb.pop_front();
            if ({ack, owner, cellval_out} !== {3'(1 << e.own), 3'(e.own), e.frame}) begin
                miscompares++;
                $display("FAIL late_first_grant: got ack=%b owner=%0d frame=%h expected ack=001 owner=0 frame=%h",
                         ack, owner, cellval_out, e.frame);
            end
        end
        g0  = cyc;
        req = 3'b000;
        tick();
        req = 3'b100;
        sb.push_back('{2, fr2, g0 + 4});
        wait_ack(10, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL late_second_grant: no ack seen expected ack=100");
        end else begin
            e = sb.pop_front();
            if ({ack, owner, cellval_out, busy} !== {3'(1 << e.own), 3'(e.own), e.frame, 1'b1}) begin
                miscompares++;
                $display("FAIL late_second_grant: got ack=%b owner=%0d frame=%h busy=%b expected ack=100 owner=2 frame=%h busy=1",
                         ack, owner, cellval_out, busy, e.frame);
            end
            vectors++;
            if (cyc !== e.cyc) begin
                miscompares++;
                $display("FAIL late_grant_time: got cycle %0d expected %0d", cyc, e.cyc);
            end
        end
        req = 3'b000;
    endtask

    task automatic test_frame_sampling();
        bit got;
        do_reset();
        fr0 = 32'h11111111;
        req = 3'b001;
        sb.push_back('{0, 32'h11111111, cyc + 1});
        wait_ack(10, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL sample_grant: no ack seen expected ack=001");
        end else begin
            e = sb.pop_front();
            if ({ack, owner, cellval_out} !== {3'(1 << e.own), 3'(e.own), e.frame}) begin
                miscompares++;
                $display("FAIL sample_grant: got ack=%b owner=%0d frame=%h expected ack=001 owner=0 frame=%h",
                         ack, owner, cellval_out, e.frame);
            end
        end
        req = 3'b000;
        fr0 = 32'h22222222;
        for (int i = 1; i < 4; i++) begin
            tick();
            vectors++;
            if (cellval_out !== 32'h11111111) begin
                miscompares++;
                $display("FAIL sample_hold dwell %0d: got frame=%h expected 11111111", i, cellval_out);
            end
        end
    endtask

    task automatic test_reset_mid_show();
        bit got;
        do_reset();
        fr0 = 32'h5A5A5A5A;
        req = 3'b001;
        sb.push_back('{0, fr0, cyc + 1});
        wait_ack(10, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL midrst_grant: no ack seen expected ack=001");
        end else begin
            e = sb.pop_front();
            if ({ack, owner, cellval_out} !== {3'(1 << e.own), 3'(e.own), e.frame}) begin
                miscompares++;
                $display("FAIL midrst_grant: got ack=%b owner=%0d frame=%h expected ack=001 owner=0 frame=%h",
                         ack, owner, cellval_out, e.frame);
            end
        end
        req = 3'b111;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        vectors++;
        if ({cellval_out, owner, ack, busy} !== 39'd0) begin
            miscompares++;
            $display("FAIL midrst_values: got %h expected 0", {cellval_out, owner, ack, busy});
        end
        resetn = 1'b1;
        sb.push_back('{0, fr0, cyc + 1});
        wait_ack(10, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL midrst_regrant: no ack seen expected ack=001");
        end else begin
            e = sb.pop_front();
            if ({ack, owner, cellval_out, busy} !== {3'(1 << e.own), 3'(e.own), e.frame, 1'b1}) begin
                miscompares++;
                $display("FAIL midrst_regrant: got ack=%b owner=%0d frame=%h busy=%b expected ack=001 owner=0 frame=%h busy=1",
                         ack, owner, cellval_out, busy, e.frame);
            end
            vectors++;
            if (cyc !== e.cyc) begin
                miscompares++;
                $display("FAIL midrst_regrant_time: got cycle %0d expected %0d", cyc, e.cyc);
            end
        end
        req = 3'b000;
    endtask

    initial begin
        resetn = 1'b0;
        req    = 3'b000;
        fr0 = '0; fr1 = '0; fr2 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_late_arrival();
        test_frame_sampling();
        test_reset_mid_show();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending grants expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
